// File: rtl/seg_pkg.sv
// Shared widths, active-high hex font and pin polarity helpers for the 7-segment scanner.
// Latency: n/a (constants and pure functions).
// Backpressure: n/a.
package seg_pkg;

    localparam int SEG_W   = 8;
    localparam int MAX_DIG = 8;

    // Segment order {g,f,e,d,c,b,a}, 1 = lit.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] f;
        f = 7'h00;
        case (nib)
            4'h0: f = 7'h3F;
            4'h1: f = 7'h06;
            4'h2: f = 7'h5B;
            4'h3: f = 7'h4F;
            4'h4: f = 7'h66;
            4'h5: f = 7'h6D;
            4'h6: f = 7'h7D;
            4'h7: f = 7'h07;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h6F;
            4'hA: f = 7'h77;
            4'hB: f = 7'h7C;
            4'hC: f = 7'h39;
            4'hD: f = 7'h5E;
            4'hE: f = 7'h79;
            4'hF: f = 7'h71;
            default: f = 7'h00;
        endcase
        return f;
    endfunction

    function automatic logic [SEG_W-1:0] seg_off(input bit act_low);
        return act_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    endfunction

    function automatic logic [MAX_DIG-1:0] sel_off(input bit act_low);
        return act_low ? {MAX_DIG{1'b1}} : {MAX_DIG{1'b0}};
    endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Nibble + decimal point to active-high {dp,g,f,e,d,c,b,a} pattern.
// Latency: combinational.
// Backpressure: none.
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0]       nib,
    input  logic             dp,
    output logic [SEG_W-1:0] pat
);

    assign pat = {dp, hex_font(nib)};

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner; optional brightness PWM when SEG_DIM_EN is defined.
// Latency: sel/seg registered, 1 cycle behind the scan counters; new values shown from next frame.
// Backpressure: none; upd is a fire-and-forget load strobe, last one before frame wrap wins.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIG     = 6,
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_CYC   = 4,
    parameter int SEL_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd,
    input  logic [4*NUM_DIG-1:0] din,
    input  logic [NUM_DIG-1:0]   dp,
    input  logic [NUM_DIG-1:0]   en_mask,
`ifdef SEG_DIM_EN
    input  logic [2:0]           bright,
`endif
    output logic [NUM_DIG-1:0]   sel,
    output logic [SEG_W-1:0]     seg,
    output logic                 frame_start
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(NUM_DIG);

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIG - 1);
    localparam logic [DIV_W-1:0]   BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [NUM_DIG-1:0] SEL_OFF   = NUM_DIG'(sel_off(SEL_ACT_LOW != 0));
    localparam logic [SEG_W-1:0]   SEG_OFF   = seg_off(SEG_ACT_LOW != 0);

    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] dig_idx;
    logic             slot_tick;
    logic             frame_wrap;

    assign slot_tick   = (div_cnt == DIV_LAST);
    assign frame_wrap  = slot_tick && (dig_idx == IDX_LAST);
    assign frame_start = !rst && (div_cnt == '0) && (dig_idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (slot_tick) begin
            div_cnt <= '0;
            dig_idx <= frame_wrap ? '0 : dig_idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Shadow captures every upd; display only swaps at frame wrap so a frame never tears.
    logic [NUM_DIG-1:0][3:0] shd_dat;
    logic [NUM_DIG-1:0]      shd_dp;
    logic [NUM_DIG-1:0]      shd_en;
    logic [NUM_DIG-1:0][3:0] dsp_dat;
    logic [NUM_DIG-1:0]      dsp_dp;
    logic [NUM_DIG-1:0]      dsp_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            shd_dat <= '0;
            shd_dp  <= '0;
            shd_en  <= '0;
            dsp_dat <= '0;
            dsp_dp  <= '0;
            dsp_en  <= '0;
        end else begin
            if (upd) begin
                shd_dat <= din;
                shd_dp  <= dp;
                shd_en  <= en_mask;
            end
            if (frame_wrap) begin
                if (upd) begin
                    dsp_dat <= din;
                    dsp_dp  <= dp;
                    dsp_en  <= en_mask;
                end else begin
                    dsp_dat <= shd_dat;
                    dsp_dp  <= shd_dp;
                    dsp_en  <= shd_en;
                end
            end
        end
    end

    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic             cur_en;
    logic [SEG_W-1:0] font_pat;

    assign cur_nib = dsp_dat[dig_idx];
    assign cur_dp  = dsp_dp[dig_idx];
    assign cur_en  = dsp_en[dig_idx];

    seg_hex_font u_font (
        .nib (cur_nib),
        .dp  (cur_dp),
        .pat (font_pat)
    );

    logic dim_on;

`ifdef SEG_DIM_EN
    // Slot split into 8 equal phases; sel only lit in phases 0..bright.
    localparam int PH_LEN = CLK_DIV / 8;
    localparam int PH_W   = $clog2(PH_LEN);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_LEN - 1);

    logic [PH_W-1:0] ph_cnt;
    logic [2:0]      phase;

    always_ff @(posedge clk) begin
        if (rst || slot_tick) begin
            ph_cnt <= '0;
            phase  <= '0;
        end else if (ph_cnt == PH_LAST) begin
            ph_cnt <= '0;
            phase  <= phase + 1'b1;
        end else begin
            ph_cnt <= ph_cnt + 1'b1;
        end
    end

    assign dim_on = (phase <= bright);
`else
    assign dim_on = 1'b1;
`endif

    logic                 in_blank;
    logic                 sel_on;
    logic [NUM_DIG-1:0]   sel_hot;
    logic [SEG_W-1:0]     seg_hot;

    assign in_blank = (div_cnt < BLANK_END);
    assign sel_on   = cur_en && !in_blank && dim_on;
    assign sel_hot  = sel_on ? (NUM_DIG'(1) << dig_idx) : '0;
    // seg follows the digit from the first cycle of the slot; blanking only acts on sel.
    assign seg_hot  = cur_en ? font_pat : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= SEL_OFF;
            seg <= SEG_OFF;
        end else begin
            sel <= sel_hot ^ SEL_OFF;
            seg <= seg_hot ^ SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus pushes one expected entry per lit digit slot,
// the monitor pops one per sel activation and checks sel, seg and lit length.
module tb_seg_scan_mux;

    localparam int ND  = 6;
    localparam int BLK = 4;
`ifdef SEG_DIM_EN
    localparam int SL     = 64;
    localparam int LEN_LO = 2 * (SL / 8) - BLK;
`else
    localparam int SL     = 16;
    localparam int LEN_LO = SL - BLK;
`endif
    localparam int LEN_HI = SL - BLK;
    localparam int FR     = ND * SL;

    logic          clk = 1'b0;
    logic          rst;
    logic          upd;
    logic [4*ND-1:0] din;
    logic [ND-1:0] dp;
    logic [ND-1:0] en_mask;
`ifdef SEG_DIM_EN
    logic [2:0]    bright;
`endif
    logic [ND-1:0] sel;
    logic [7:0]    seg;
    logic          frame_start;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIG     (ND),
        .CLK_DIV     (SL),
        .BLANK_CYC   (BLK),
        .SEL_ACT_LOW (1),
        .SEG_ACT_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .upd         (upd),
        .din         (din),
        .dp          (dp),
        .en_mask     (en_mask),
`ifdef SEG_DIM_EN
        .bright      (bright),
`endif
        .sel         (sel),
        .seg         (seg),
        .frame_start (frame_start)
    );

    // Active-low pin patterns, index = digit.
    logic [7:0] seg_123456 [ND] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    logic [7:0] seg_fedcba [ND] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};

    typedef struct {
        logic [ND-1:0] sel;
        logic [7:0]    seg;
        int            len;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [7:0] s, input int len);
        exp_t e;
        e.sel = ~(ND'(1) << d);
        e.seg = s;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 2 * FR + 4) begin
            @(negedge clk);
            n++;
        end
        if (frame_start !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_fs_%s: frame_start not seen within %0d cycles", nm, n);
        end
    endtask

    // Monitor: one scoreboard entry per sel activation.
    bit   in_run  = 1'b0;
    int   run_len = 0;
    int   exp_len = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            in_run = 1'b0;
        end else if (sel !== {ND{1'b1}}) begin
            if (!in_run) begin
                in_run  = 1'b1;
                run_len = 1;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    exp_len = 0;
                    $display("FAIL unexpected_sel: got sel=0x%0h seg=0x%0h with empty scoreboard", sel, seg);
                end else begin
                    cur = sb.pop_front();
                    exp_len = cur.len;
                    chk("mon_sel", 32'(sel), 32'(cur.sel));
                    chk("mon_seg", 32'(seg), 32'(cur.seg));
                end
            end else begin
                run_len++;
            end
        end else if (in_run) begin
            in_run = 1'b0;
            chk("mon_run_len", run_len, exp_len);
        end
    end

    initial begin
        int n;
        rst     = 1'b1;
        upd     = 1'b0;
        din     = '0;
        dp      = '0;
        en_mask = '0;
`ifdef SEG_DIM_EN
        bright  = 3'd7;
`endif
        // Reset held for three cycles.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_sel", 32'(sel), 32'h3F);
            chk("rst_seg", 32'(seg), 32'hFF);
            chk("rst_fs", 32'(frame_start), 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("fs_after_rst", 32'(frame_start), 32'h1);
        mon_en = 1'b1;

        // Frame 0 is dark; load 654321 for frame 1.
        din = 24'h654321; dp = 6'h00; en_mask = 6'h3F; upd = 1'b1;
        step();
        upd = 1'b0;
        chk("fs_one_cycle", 32'(frame_start), 32'h0);
        for (int d = 0; d < ND; d++) push(d, seg_123456[d], LEN_HI);

        wait_fs("f1");
        n = 0;
        while (sel[0] !== 1'b0 && n < 2 * SL) begin
            @(negedge clk);
            n++;
        end
        chk("sel0_latency", n, BLK + 1);

        // Mid digit 3: new value must wait for next frame.
        repeat (3 * SL + SL / 2 - (BLK + 1)) step();
        din = 24'hABCDEF; upd = 1'b1;
        step();
        upd = 1'b0;
        for (int d = 0; d < ND; d++) push(d, seg_fedcba[d], LEN_HI);

        // upd on the wrap cycle goes straight to the display.
        wait_fs("f2");
        repeat (FR - 1) step();
        din = 24'h654321; dp = 6'b000001; en_mask = 6'b101010; upd = 1'b1;
        step();
        upd = 1'b0;
        push(1, 8'hA4, LEN_HI);
        push(3, 8'h99, LEN_HI);
        push(5, 8'h82, LEN_HI);

        en_mask = 6'h3F; upd = 1'b1;
        step();
        upd = 1'b0;
        push(0, 8'h79, LEN_HI);
        for (int d = 1; d < 5; d++) push(d, seg_123456[d], LEN_HI);

        // Reset in the middle of digit 4.
        wait_fs("f4");
        repeat (4 * SL + 6) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_sel", 32'(sel), 32'h3F);
        chk("midrst_seg", 32'(seg), 32'hFF);
        chk("midrst_fs", 32'(frame_start), 32'h0);
        chk("midrst_sb_empty", sb.size(), 0);
        rst = 1'b0;
        #1;
        chk("fs_after_midrst", 32'(frame_start), 32'h1);

`ifdef SEG_DIM_EN
        bright = 3'd1;
`endif
        din = 24'h654321; dp = 6'h00; en_mask = 6'h3F; upd = 1'b1;
        step();
        upd = 1'b0;
        for (int d = 0; d < ND; d++) push(d, seg_123456[d], LEN_LO);

        wait_fs("r1");
        wait_fs("r2");
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
